// File: rtl/j1p_core.sv
// j1p_core: parametrised J1 stack CPU with external code/data ports, IO wait states and
// sticky stack-fault flags. Optional build macro J1P_FAULT_HALT_EN freezes the core on a fault.
module j1p_core #(
    parameter int PC_W      = 13,
    parameter int RAM_AW    = 13,
    parameter int DSTACK_AW = 5,
    parameter int RSTACK_AW = 5
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    output logic [PC_W-1:0]   code_addr,
    input  logic [15:0]       code_din,
    output logic [RAM_AW-1:0] mem_raddr,
    input  logic [15:0]       mem_rdata,
    output logic [RAM_AW-1:0] mem_waddr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic [15:0]       io_addr,
    output logic [15:0]       io_dout,
    input  logic [15:0]       io_din,
    input  logic              io_ready,
    output logic [3:0]        stk_fault,
    output logic              halted
);

    logic [PC_W-1:0]      pc, pc_n, pc_plus1, target;
    logic [15:0]          t, t_n, n, r, alu, fetch_data, rstk_wd, t_next_eff;
    logic [DSTACK_AW-1:0] dsp, dsp_n;
    logic [RSTACK_AW-1:0] rsp, rsp_n;
    logic [1:0]           dd, rd;
    logic                 dstk_we, rstk_we;
    logic                 is_lit, is_alu, io_space, stall, commit, frozen;
    logic [3:0]           op, fault_new;
    logic [15:0]          insn;

    logic [15:0] dstk [2**DSTACK_AW];
    logic [15:0] rstk [2**RSTACK_AW];

    assign insn     = code_din;
    assign n        = dstk[dsp];
    assign r        = rstk[rsp];
    assign op       = insn[11:8];
    assign is_lit   = insn[15];
    assign is_alu   = (insn[15:13] == 3'b011);
    assign io_space = (t[15:14] != 2'b00);
    assign pc_plus1 = pc + PC_W'(1);
    assign target   = PC_W'(insn[12:0]);

    assign fetch_data = io_space ? io_din : mem_rdata;

    always_comb begin
        alu = t;
        case (op)
            4'd0:  alu = t;
            4'd1:  alu = n;
            4'd2:  alu = t + n;
            4'd3:  alu = t & n;
            4'd4:  alu = t | n;
            4'd5:  alu = t ^ n;
            4'd6:  alu = ~t;
            4'd7:  alu = {16{n == t}};
            4'd8:  alu = {16{$signed(n) < $signed(t)}};
            4'd9:  alu = n >> t[3:0];
            4'd10: alu = t - 16'd1;
            4'd11: alu = r;
            4'd12: alu = fetch_data;
            4'd13: alu = n << t[3:0];
            4'd14: alu = {8'(rsp), 8'(dsp)};
            4'd15: alu = {16{n < t}};
            default: alu = t;
        endcase
    end

    always_comb begin
        pc_n    = pc_plus1;
        t_n     = t;
        dd      = 2'b00;
        rd      = 2'b00;
        dstk_we = 1'b0;
        rstk_we = 1'b0;
        rstk_wd = t;
        if (is_lit) begin
            t_n     = {1'b0, insn[14:0]};
            dd      = 2'b01;
            dstk_we = 1'b1;
        end else begin
            case (insn[14:13])
                2'b00: pc_n = target;
                2'b01: begin
                    pc_n = (t == 16'd0) ? target : pc_plus1;
                    t_n  = n;
                    dd   = 2'b11;
                end
                2'b10: begin
                    pc_n    = target;
                    rd      = 2'b01;
                    rstk_we = 1'b1;
                    rstk_wd = 16'({pc_plus1, 1'b0});
                end
                default: begin
                    t_n     = alu;
                    if (insn[12]) pc_n = r[PC_W:1];
                    dd      = insn[1:0];
                    rd      = insn[3:2];
                    dstk_we = insn[7];
                    rstk_we = insn[6];
                end
            endcase
        end
    end

    // 2-bit signed deltas; the pointers wrap modulo the stack depth
    assign dsp_n = dsp + {{(DSTACK_AW-1){dd[1]}}, dd[0]};
    assign rsp_n = rsp + {{(RSTACK_AW-1){rd[1]}}, rd[0]};

    assign fault_new = {(rsp == '1) && (rd == 2'b01), (rsp == '0) && (rd == 2'b11),
                        (dsp == '1) && (dd == 2'b01), (dsp == '0) && (dd == 2'b11)};

    assign io_rd  = is_alu && (op == 4'd12) && io_space && !sys_rst_i && !frozen;
    assign io_wr  = is_alu && insn[5] && io_space && !sys_rst_i && !frozen;
    assign mem_we = is_alu && insn[5] && !io_space && !sys_rst_i && !frozen;
    assign stall  = (io_rd || io_wr) && !io_ready;
    assign commit = !sys_rst_i && !stall && !frozen;

    // While stalled or frozen the ROM re-reads the current instruction
    assign code_addr  = sys_rst_i ? '0 : (commit ? pc_n : pc);
    assign t_next_eff = sys_rst_i ? '0 : (commit ? t_n : t);
    assign mem_raddr  = t_next_eff[RAM_AW:1];
    assign mem_waddr  = t[RAM_AW:1];
    assign mem_wdata  = n;
    assign io_addr    = t;
    assign io_dout    = n;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            pc        <= '0;
            t         <= '0;
            dsp       <= '0;
            rsp       <= '0;
            stk_fault <= '0;
        end else if (commit) begin
            pc        <= pc_n;
            t         <= t_n;
            dsp       <= dsp_n;
            rsp       <= rsp_n;
            stk_fault <= stk_fault | fault_new;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (commit) begin
            if (dstk_we) dstk[dsp_n] <= t;
            if (rstk_we) rstk[rsp_n] <= rstk_wd;
        end
    end

`ifdef J1P_FAULT_HALT_EN
    typedef enum logic {ST_RUN, ST_HALT} state_t;
    state_t state;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else if (commit && ((fault_new & ~stk_fault) != 4'b0000)) begin
            state  <= ST_HALT;
            halted <= 1'b1;
        end
    end

    assign frozen = (state == ST_HALT);
`else
    assign frozen = 1'b0;
    assign halted = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{insn[4], t_next_eff};

endmodule
